bcd_scan_display: RTL and testbench

Time-multiplexed seven-segment driver downstream of the team's mod-10 up/down digit counters. Captures a packed multi-digit BCD value into a hold register on `load`, then scans one digit at a time onto a shared segment bus with one-hot active-low digit enables. Includes inter-digit dead time, invalid-nibble detection and a per-frame pulse. Typical use: a counter chain's digit buses feed `digits`, and its terminal-count/carry output (or a periodic strobe) feeds `load`.

---
 rtl/bcd_disp_pkg.sv | 23 ++
 rtl/bcd_to_seg.sv | 25 ++
 rtl/bcd_scan_display.sv | 124 ++++++++++++
 tb/tb_bcd_scan_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD scan display: segment patterns (bit 0 = a .. bit 6 = g,
// active-high) and the scan-index width helper.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Index width never drops below one bit so NDIG=1 still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment scanner with dead cycle, sticky invalid-nibble flag and
// frame pulse. Define SCAN_LZB_EN to enable leading-zero blanking.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 50000
) (
    input  logic              clk,
    input  logic              R,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              err,
    output logic              frame
);

    localparam int IW = idx_width(NDIG);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("bcd_scan_display: DIV must be >= 2");
    end
    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
        $error("bcd_scan_display: NDIG must be in 1..8");
    end

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   dead_q, dead_d;
    logic [NDIG-1:0][3:0]   hold_q, hold_d;
    logic                   err_q, err_d;
    logic [6:0]             seg_q, seg_d;
    logic [NDIG-1:0]        an_q, an_d;
    logic                   frame_q, frame_d;

    logic                   tick;
    logic                   bad_nib;
    logic [NDIG-1:0]        lzb;
    logic [6:0]             dec_seg;

    bcd_to_seg u_dec (
        .bcd (hold_q[idx_q]),
        .seg (dec_seg)
    );

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        bad_nib = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (digits[4*k +: 4] > 4'd9) bad_nib = 1'b1;
        end
    end

`ifdef SCAN_LZB_EN
    // Walk down from the most significant digit; a digit goes dark while everything
    // above it (and itself) is zero. Digit 0 is never masked.
    logic lz_run;
    always_comb begin
        lz_run = 1'b1;
        lzb    = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            lz_run = lz_run & (hold_q[k] == 4'd0);
            if (k != 0) lzb[k] = lz_run;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        dead_d  = tick;
        hold_d  = hold_q;
        err_d   = err_q;
        if (tick) idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        if (load) begin
            hold_d = digits;
            if (bad_nib) err_d = 1'b1;
        end

        // Outputs sample the pre-edge state, so a slot change shows one dark cycle
        // before the new digit is enabled.
        an_d  = '1;
        seg_d = SEG_OFF;
        if (!(blank || dead_q || lzb[idx_q])) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
        end
        frame_d = dead_q && (idx_q == '0);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            dead_q  <= 1'b0;
            hold_q  <= '0;
            err_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign err   = err_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with NDIG=4, DIV=4; edges counted from reset release.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        R;
    logic        load;
    logic [15:0] digits;
    logic        blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        frame;

    int tests = 0;
    int fails = 0;
    int e     = 0;

    bcd_scan_display #(.NDIG(4), .DIV(4)) dut (
        .clk    (clk),
        .R      (R),
        .load   (load),
        .digits (digits),
        .blank  (blank),
        .seg    (seg),
        .an     (an),
        .err    (err),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after edge k (sampled on the following falling edge).
    task automatic goto(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        @(negedge clk);
    endtask

    initial begin
        R = 1'b0; load = 1'b0; digits = '0; blank = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_frame", 32'(frame), 32'h0);

        // Release and load 1234 on the first edge.
        R = 1'b1; e = 0;
        load = 1'b1; digits = 16'h1234;
        goto(1);
        load = 1'b0;
        chk("e1_old_hold", 32'(seg), 32'(7'b0111111));
        goto(2);
        chk("d0_an", 32'(an), 32'hE);
        chk("d0_seg4", 32'(seg), 32'(7'b1100110));
        goto(5);
        chk("dead_an", 32'(an), 32'hF);
        chk("dead_seg", 32'(seg), 32'h0);
        goto(6);
        chk("d1_an", 32'(an), 32'hD);
        chk("d1_seg3", 32'(seg), 32'(7'b1001111));
        goto(10);
        chk("d2_an", 32'(an), 32'hB);
        chk("d2_seg2", 32'(seg), 32'(7'b1011011));
        goto(14);
        chk("d3_an", 32'(an), 32'h7);
        chk("d3_seg1", 32'(seg), 32'(7'b0000110));
        goto(16);
        chk("frame_pre", 32'(frame), 32'h0);
        goto(17);
        chk("frame_hi", 32'(frame), 32'h1);
        chk("frame_dead_an", 32'(an), 32'hF);
        goto(18);
        chk("frame_lo", 32'(frame), 32'h0);
        chk("wrap_d0_an", 32'(an), 32'hE);

        // 0070: leading-zero behaviour.
        load = 1'b1; digits = 16'h0070;
        goto(19);
        load = 1'b0;
        goto(20);
        chk("z_d0_seg", 32'(seg), 32'(7'b0111111));
        goto(22);
        chk("z_d1_an", 32'(an), 32'hD);
        chk("z_d1_seg7", 32'(seg), 32'(7'b0000111));
        goto(26);
`ifdef SCAN_LZB_EN
        chk("z_d2_an", 32'(an), 32'hF);
        chk("z_d2_seg", 32'(seg), 32'h0);
`else
        chk("z_d2_an", 32'(an), 32'hB);
        chk("z_d2_seg", 32'(seg), 32'(7'b0111111));
`endif
        goto(30);
`ifdef SCAN_LZB_EN
        chk("z_d3_an", 32'(an), 32'hF);
`else
        chk("z_d3_an", 32'(an), 32'h7);
        chk("z_d3_seg", 32'(seg), 32'(7'b0111111));
`endif
        goto(34);
        chk("z_d0_an", 32'(an), 32'hE);
        chk("z_err", 32'(err), 32'h0);

        // 00A5: invalid nibble sets sticky err, shows dash.
        load = 1'b1; digits = 16'h00A5;
        goto(35);
        load = 1'b0;
        chk("err_set", 32'(err), 32'h1);
        goto(38);
        chk("dash_an", 32'(an), 32'hD);
        chk("dash_seg", 32'(seg), 32'(7'b1000000));
        load = 1'b1; digits = 16'h0000;
        goto(39);
        load = 1'b0;
        goto(40);
        chk("err_sticky", 32'(err), 32'h1);

        // Load coincident with the tick at edge 44 (idx 2 -> 3).
        goto(43);
        load = 1'b1; digits = 16'h5678;
        goto(44);
        load = 1'b0;
        goto(45);
        chk("lt_dead", 32'(an), 32'hF);
        goto(46);
        chk("lt_an", 32'(an), 32'h7);
        chk("lt_seg5", 32'(seg), 32'(7'b1101101));

        // Blank mid-slot; frame keeps pulsing.
        blank = 1'b1;
        goto(47);
        chk("blank_an", 32'(an), 32'hF);
        chk("blank_seg", 32'(seg), 32'h0);
        goto(49);
        chk("blank_frame1", 32'(frame), 32'h1);
        goto(50);
        chk("blank_frame_lo", 32'(frame), 32'h0);
        goto(65);
        chk("blank_frame2", 32'(frame), 32'h1);
        blank = 1'b0;
        goto(66);
        chk("unblank_an", 32'(an), 32'hE);
        chk("unblank_seg8", 32'(seg), 32'(7'b1111111));

        // Asynchronous reset between edges.
        R = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        R = 1'b1; e = 0;
        goto(1);
        chk("rs_d0_an", 32'(an), 32'hE);
        chk("rs_d0_seg", 32'(seg), 32'(7'b0111111));
        goto(5);
        chk("rs_dead", 32'(an), 32'hF);
        goto(6);
`ifdef SCAN_LZB_EN
        chk("rs_d1_an", 32'(an), 32'hF);
`else
        chk("rs_d1_an", 32'(an), 32'hD);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
